// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down counter family.
package counter_pkg;

   localparam int DW_DEF    = 8;
   localparam int WIDTH_DEF = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } cnt_state_t;

endpackage

// File: rtl/counter_up_ctl.sv
// Count-up controller: counts 0..WIDTH under start/stop/ena control,
// either wrapping (counting laps) or halting at the terminal count.
module counter_up_ctl
   import counter_pkg::*;
#(
   parameter int dw    = DW_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter bit WRAP  = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          ena,
   input  logic          load,
   input  logic [dw-1:0] load_val,
   output logic [dw-1:0] result,
   output logic          busy,
   output logic          done,
   output logic [dw-1:0] laps
);

   localparam logic [dw-1:0] TERM = dw'(WIDTH);
   localparam logic [dw-1:0] ONE  = dw'(1);
   localparam logic [dw-1:0] MAXV = '1;

   if (WIDTH < 0 || WIDTH >= (2 ** dw)) begin : g_width_chk
      $error("counter_up_ctl: WIDTH must fit in dw bits");
   end

   cnt_state_t    state;
   logic [dw-1:0] load_sat;

   // A preset never leaves the count beyond the terminal value.
   assign load_sat = (load_val > TERM) ? TERM : load_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         result <= '0;
         laps   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            result <= load_sat;
         end else if (stop && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (start) begin
            result <= '0;
            laps   <= '0;
            state  <= RUN;
            busy   <= 1'b1;
         end else if (ena && state == RUN) begin
            if (result >= TERM) begin
               done <= 1'b1;
               if (WRAP) begin
                  result <= '0;
                  if (laps != MAXV) laps <= laps + ONE;
               end else begin
                  state <= HALT;
                  busy  <= 1'b0;
               end
            end else begin
               result <= result + ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_up_ctl.sv
// Directed bench: a wrapping and a halting instance share all stimulus.
module tb_counter_up_ctl;
   import counter_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0, stop = 1'b0, ena = 1'b0, load = 1'b0;
   logic [7:0] load_val = '0;
   logic [7:0] w_result, w_laps, h_result, h_laps;
   logic       w_busy, w_done, h_busy, h_done;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   counter_up_ctl #(.dw(8), .WIDTH(7), .WRAP(1'b1)) u_w (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .ena(ena),
      .load(load), .load_val(load_val), .result(w_result), .busy(w_busy),
      .done(w_done), .laps(w_laps));

   counter_up_ctl #(.dw(8), .WIDTH(7), .WRAP(1'b0)) u_h (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .ena(ena),
      .load(load), .load_val(load_val), .result(h_result), .busy(h_busy),
      .done(h_done), .laps(h_laps));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held for two cycles
      repeat (2) step();
      chk("rst_w_result", w_result, 0);
      chk("rst_w_laps",   w_laps,   0);
      chk("rst_w_busy",   w_busy,   0);
      chk("rst_w_done",   w_done,   0);
      chk("rst_h_result", h_result, 0);
      reset = 1'b1;
      ena = 1'b1;
      step();
      chk("idle_ena_result", w_result, 0);
      chk("idle_ena_busy",   w_busy,   0);

      // start, then 10 enabled edges
      ena = 1'b0; start = 1'b1;
      step();
      chk("start_busy",   w_busy,   1);
      chk("start_result", w_result, 0);
      start = 1'b0; ena = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk($sformatf("wrap_result_%0d", i), w_result, i % 8);
         chk($sformatf("wrap_done_%0d", i),   w_done,   (i == 8));
         chk($sformatf("halt_result_%0d", i), h_result, (i > 7) ? 7 : i);
         chk($sformatf("halt_done_%0d", i),   h_done,   (i == 8));
         chk($sformatf("halt_busy_%0d", i),   h_busy,   (i < 8));
      end
      chk("wrap_laps", w_laps, 1);
      chk("halt_laps", h_laps, 0);
      chk("halt_state", (u_h.state === HALT), 1);

      // load saturates to terminal count and suppresses the increment
      ena = 1'b0; start = 1'b1;
      step();
      start = 1'b0; ena = 1'b1;
      repeat (4) step();
      chk("pre_load_result", w_result, 4);
      load = 1'b1; load_val = 8'd200;
      step();
      chk("load_result", w_result, 7);
      chk("load_done",   w_done,   0);
      chk("load_busy",   w_busy,   1);
      load = 1'b0;
      step();
      chk("post_load_result", w_result, 0);
      chk("post_load_done",   w_done,   1);
      chk("post_load_laps",   w_laps,   1);
      ena = 1'b0;
      step();
      chk("done_one_cycle", w_done, 0);

      // stop beats start
      start = 1'b1;
      step();
      start = 1'b0; ena = 1'b1;
      repeat (3) step();
      chk("pre_stop_result", w_result, 3);
      ena = 1'b0; stop = 1'b1; start = 1'b1;
      step();
      chk("stop_busy",   w_busy,   0);
      chk("stop_result", w_result, 3);
      chk("stop_state",  (u_w.state === IDLE), 1);
      stop = 1'b0; start = 1'b0; ena = 1'b1;
      step();
      chk("idle_hold_result", w_result, 3);

      // load while idle keeps the state
      ena = 1'b0; load = 1'b1; load_val = 8'd5;
      step();
      load = 1'b0;
      chk("idle_load_result", w_result, 5);
      chk("idle_load_busy",   w_busy,   0);

      // asynchronous reset mid-count
      start = 1'b1;
      step();
      start = 1'b0; ena = 1'b1;
      repeat (5) step();
      chk("pre_rst_result", w_result, 5);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_result", w_result, 0);
      chk("async_rst_busy",   w_busy,   0);
      chk("async_rst_done",   w_done,   0);
      #1 reset = 1'b1;
      step();
      chk("after_rst_result", w_result, 0);
      chk("after_rst_done",   w_done,   0);
      ena = 1'b0; start = 1'b1;
      step();
      start = 1'b0; ena = 1'b1;
      step();
      chk("restart_result", w_result, 1);
      chk("restart_busy",   w_busy,   1);

      // restart while running clears the count, then laps saturation
      start = 1'b1;
      step();
      chk("rerun_result", w_result, 0);
      chk("rerun_done",   w_done,   0);
      start = 1'b0;
      repeat (8 * 257) step();
      chk("laps_saturate", w_laps,   255);
      chk("laps_result",   w_result, 0);
      ena = 1'b0; stop = 1'b1;
      step();
      stop = 1'b0;
      chk("final_busy", w_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_up_ctl.md
COUNTER_UP_CTL -- requirements
Module: counter_up_ctl

Interface
REQ-001 Parameter dw SHALL default to 8 and sets the width of result, load_val and laps.
REQ-002 Parameter WIDTH SHALL default to 7 and is the terminal count; the count runs 0 up to WIDTH.
REQ-003 Parameter WRAP SHALL default to 1; 1 selects wrap-around at terminal count, 0 selects halt at terminal count.
REQ-004 Port clk SHALL be a 1-bit input: the single clock, rising-edge active.
REQ-005 Port reset SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-006 Port start SHALL be a 1-bit input: begin a count from 0.
REQ-007 Port stop SHALL be a 1-bit input: abort the count and return to IDLE.
REQ-008 Port ena SHALL be a 1-bit input: count enable, effective only in RUN.
REQ-009 Port load SHALL be a 1-bit input: synchronous preset of result.
REQ-010 Port load_val SHALL be a dw-bit input: the preset value.
REQ-011 Port result SHALL be a dw-bit output: the current count.
REQ-012 Port busy SHALL be a 1-bit output: high while in RUN.
REQ-013 Port done SHALL be a 1-bit output: one-cycle terminal-count pulse.
REQ-014 Port laps SHALL be a dw-bit output: the number of wraps since the last start.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and HALT.
REQ-016 IDLE: start SHALL clear result and laps to 0 and move to RUN on the next edge.
REQ-017 RUN with ena=1 and result<WIDTH: result SHALL increment by 1 per edge.
REQ-018 RUN with ena=0: result SHALL hold.
REQ-019 RUN with ena=1 and result==WIDTH, WRAP=1: result SHALL become 0, laps SHALL increment, and done SHALL pulse high for one cycle; the state stays RUN.
REQ-020 Laps increments SHALL saturate at all-ones and never wrap.
REQ-021 RUN with ena=1 and result==WIDTH, WRAP=0: result SHALL hold at WIDTH, done SHALL pulse for one cycle, and the state SHALL go to HALT.
REQ-022 HALT: result SHALL hold and ena SHALL be ignored; start SHALL behave as in IDLE; stop SHALL go to IDLE with result held.
REQ-023 stop in RUN SHALL go to IDLE on the next edge with result and laps held.
REQ-024 stop in IDLE SHALL have no effect.
REQ-025 load, in any state, SHALL set result to min(load_val, WIDTH) on the next edge without changing the FSM state.
REQ-026 Priority for simultaneous inputs in one cycle SHALL be: load > stop > start > ena.
REQ-027 load and ena together in RUN SHALL load only, with no increment and no done.
REQ-028 start while already in RUN SHALL restart: result and laps cleared to 0, state stays RUN, no done.
REQ-029 done SHALL be registered: high in the cycle after the terminal-count edge and low in all other cycles.
REQ-030 busy SHALL be a registered decode of state==RUN.
REQ-031 All increments SHALL be computed dw bits wide; WIDTH SHALL be less than 2**dw, checked by an elaboration assertion.

Reset
REQ-032 When reset goes low, the block SHALL immediately enter IDLE with result=0, laps=0, busy=0, done=0.
REQ-033 Reset asserted mid-count SHALL abort the count with no done pulse.
REQ-034 The first edge after reset deasserts SHALL evaluate inputs normally.

Structure
REQ-035 A shared package counter_pkg SHALL hold the state enum typedef (cnt_state_t: IDLE, RUN, HALT) and the default constants DW_DEF=8 and WIDTH_DEF=7.
REQ-036 There SHALL be no sub-module: the FSM, counter, lap register and done register live in counter_up_ctl.
REQ-037 The block is the count-up companion to the existing count-down counter, and its port names SHALL match that counter's ports (clk, reset, ena, result) where the meaning is shared.

Verification
REQ-038 Reset low for 2 cycles, then high -> result=0, laps=0, busy=0, done=0; ena=1 alone gives no change (state IDLE).
REQ-039 start, then ena=1 for 10 cycles with WRAP=1 -> result 1,2,...,7,0,1,2; done high exactly one cycle after 7->0; laps=1.
REQ-040 WRAP=0, start, then ena=1 for 10 cycles -> result climbs to 7 and holds; one done pulse; busy drops after the terminal count; state HALT.
REQ-041 Mid-count at result=4, assert load=1 with load_val=200 together with ena=1 -> result=7 with no done; next ena edge -> wrap to 0 with done.
REQ-042 At result=3, assert stop and start in the same cycle -> stop wins: state IDLE, result=3, busy=0.
REQ-043 At result=5 in RUN, pulse reset low between edges -> result=0 immediately and no done pulse; restart via start works normally.
